// File: rtl/rd_ctrl.sv
// Read-side controller of the dual-clock gray-pointer FIFO.
// Syncs the write pointer, owns the read address, flags empty/level.
module rd_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int SYNC_DLY = 2,
    parameter int AE_THR   = 2
) (
    input  logic              rd_clk,
    input  logic              rst_,
    input  logic [ADDR_W-1:0] wr_ptr_g,
    input  logic              rd_req_,
    output logic [ADDR_W-1:0] rd_ptr_b,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_ptr_g,
    output logic              rd_valid,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level
);

    function automatic logic [ADDR_W-1:0] g2b(
        input logic [ADDR_W-1:0] g
    );
        logic [ADDR_W-1:0] b;
        b = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    logic [ADDR_W-1:0] sync_q [SYNC_DLY];
    logic [ADDR_W-1:0] wr_g_s;
    logic [ADDR_W-1:0] wr_b_s;
    logic [ADDR_W-1:0] rd_nxt;
    logic [ADDR_W-1:0] diff;
    logic              eq;
    logic              underlap;
    logic              underlap_dly;
    logic              empty_dly;

    always_ff @(posedge rd_clk or negedge rst_) begin
        if (!rst_) begin
            for (int i = 0; i < SYNC_DLY; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wr_ptr_g;
            for (int i = 1; i < SYNC_DLY; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wr_g_s   = sync_q[SYNC_DLY-1];
    assign wr_b_s   = g2b(wr_g_s);
    assign rd_nxt   = rd_ptr_b + 1'b1;
    assign diff     = wr_b_s - rd_ptr_b;
    assign eq       = (rd_ptr_b == wr_b_s);
    assign underlap = (rd_nxt == wr_b_s);
    assign rd_ptr_g = rd_ptr_b ^ (rd_ptr_b >> 1);

    // Equality after one-left means the reader caught up; otherwise full.
    assign empty = eq && (underlap_dly || empty_dly);

    always_comb begin
        level = {1'b0, diff};
        if (empty) begin
            level = '0;
        end else if (eq) begin
            level = {1'b1, {ADDR_W{1'b0}}};
        end
    end

    assign almost_empty = (level <= (ADDR_W+1)'(AE_THR));

    always_ff @(posedge rd_clk or negedge rst_) begin
        if (!rst_) begin
            rd_ptr_b     <= '0;
            rd_en        <= 1'b0;
            rd_valid     <= 1'b0;
            underlap_dly <= 1'b0;
            empty_dly    <= 1'b1;
        end else begin
            // The in-flight read counts against level to avoid overread.
            rd_en        <= !rd_req_ &&
                            (level > {{ADDR_W{1'b0}}, rd_en});
            rd_valid     <= rd_en;
            underlap_dly <= underlap;
            empty_dly    <= empty;
            if (rd_en) begin
                rd_ptr_b <= rd_nxt;
            end
        end
    end

endmodule

// File: tb/tb_rd_ctrl.sv
// Directed self-checking bench for rd_ctrl.
// Inputs change and outputs are sampled on the falling edge.
module tb_rd_ctrl;

  logic       rd_clk = 1'b0;
  logic       rst_;
  logic [3:0] wr_ptr_g;
  logic       rd_req_;
  logic [3:0] rd_ptr_b;
  logic       rd_en;
  logic [3:0] rd_ptr_g;
  logic       rd_valid;
  logic       empty;
  logic       almost_empty;
  logic [4:0] level;

  int checks = 0;
  int errors = 0;

  rd_ctrl #(
    .ADDR_W(4),
    .SYNC_DLY(2),
    .AE_THR(2)
  ) dut (
    .rd_clk       (rd_clk),
    .rst_         (rst_),
    .wr_ptr_g     (wr_ptr_g),
    .rd_req_      (rd_req_),
    .rd_ptr_b     (rd_ptr_b),
    .rd_en        (rd_en),
    .rd_ptr_g     (rd_ptr_g),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .almost_empty (almost_empty),
    .level        (level)
  );

  always #5 rd_clk = ~rd_clk;

  task automatic ck(input string tag,
                    input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL %s", tag);
    end
  endtask

  function automatic logic [3:0] gr(
    input int b
  );
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction

  task automatic neg(input int n);
    for (int i = 0; i < n; i++)
      @(negedge rd_clk);
  endtask

  task automatic do_reset(
    input logic [3:0] wg
  );
    rst_     = 1'b0;
    wr_ptr_g = wg;
    neg(2);
    rst_ = 1'b1;
  endtask

  task automatic pulse_read(input int p);
    rd_req_ = 1'b0;
    neg(1);
    ck("pulse_en", rd_en === 1'b1);
    ck("pulse_ptr", rd_ptr_b === 4'(p));
    rd_req_ = 1'b1;
    neg(2);
    ck("gap_en", rd_en === 1'b0);
  endtask

  initial begin
    rd_req_  = 1'b1;
    rst_     = 1'b0;
    wr_ptr_g = 4'b0110;
    neg(2);
    ck("rst_ptr_b", rd_ptr_b === 4'd0);
    ck("rst_ptr_g", rd_ptr_g === 4'd0);
    ck("rst_en", rd_en === 1'b0);
    ck("rst_valid", rd_valid === 1'b0);
    ck("rst_empty", empty === 1'b1);
    ck("rst_ae", almost_empty === 1'b1);
    ck("rst_level", level === 5'd0);
    rst_ = 1'b1;
    neg(1);
    ck("rel1_level", level === 5'd0);
    neg(1);
    ck("rel2_level", level === 5'd4);
    ck("rel2_empty", empty === 1'b0);
    ck("rel2_ae", almost_empty === 1'b0);

    do_reset(4'b0000);
    wr_ptr_g = gr(1);
    rd_req_  = 1'b0;
    neg(2);
    ck("se_level", level === 5'd1);
    ck("se_en0", rd_en === 1'b0);
    neg(1);
    ck("se_en", rd_en === 1'b1);
    ck("se_ptr0", rd_ptr_b === 4'd0);
    neg(1);
    ck("se_en_off", rd_en === 1'b0);
    ck("se_valid", rd_valid === 1'b1);
    ck("se_ptr1", rd_ptr_b === 4'd1);
    ck("se_empty", empty === 1'b1);
    ck("se_level0", level === 5'd0);
    neg(1);
    ck("se_valid_off", rd_valid === 1'b0);
    for (int i = 0; i < 4; i++) begin
      neg(1);
      ck("se_no_reread", rd_en === 1'b0);
    end
    ck("se_ptr_hold", rd_ptr_b === 4'd1);

    rd_req_ = 1'b1;
    do_reset(4'b0000);
    wr_ptr_g = gr(8);
    neg(3);
    ck("fill_level8", level === 5'd8);
    wr_ptr_g = gr(0);
    neg(3);
    ck("full_empty", empty === 1'b0);
    ck("full_level", level === 5'd16);
    rd_req_ = 1'b0;
    for (int i = 0; i < 16; i++) begin
      neg(1);
      ck("drain_en", rd_en === 1'b1);
      ck("drain_ptr", rd_ptr_b === 4'(i));
      if (i > 0)
        ck("drain_valid", rd_valid === 1'b1);
    end
    neg(1);
    ck("drain_end_en", rd_en === 1'b0);
    ck("drain_end_ptr", rd_ptr_b === 4'd0);
    ck("drain_end_empty", empty === 1'b1);
    ck("drain_last_valid", rd_valid === 1'b1);
    neg(1);
    ck("drain_idle_valid", rd_valid === 1'b0);
    ck("drain_idle_en", rd_en === 1'b0);

    wr_ptr_g = gr(7);
    neg(3);
    wr_ptr_g = gr(14);
    neg(20);
    ck("pre_wrap_ptr", rd_ptr_b === 4'd14);
    ck("pre_wrap_empty", empty === 1'b1);
    rd_req_  = 1'b1;
    wr_ptr_g = gr(2);
    neg(3);
    ck("wrap_level", level === 5'd4);
    rd_req_ = 1'b0;
    neg(1);
    ck("wrap_ptr14", rd_ptr_b === 4'd14);
    ck("wrap_g14", rd_ptr_g === 4'b1001);
    ck("wrap_en14", rd_en === 1'b1);
    neg(1);
    ck("wrap_ptr15", rd_ptr_b === 4'd15);
    ck("wrap_g15", rd_ptr_g === 4'b1000);
    neg(1);
    ck("wrap_ptr0", rd_ptr_b === 4'd0);
    ck("wrap_g0", rd_ptr_g === 4'b0000);
    neg(1);
    ck("wrap_ptr1", rd_ptr_b === 4'd1);
    ck("wrap_g1", rd_ptr_g === 4'b0001);
    ck("wrap_en1", rd_en === 1'b1);
    neg(1);
    ck("wrap_end_en", rd_en === 1'b0);
    ck("wrap_end_empty", empty === 1'b1);
    rd_req_ = 1'b1;

    wr_ptr_g = gr(7);
    neg(3);
    ck("ae_level5", level === 5'd5);
    ck("ae_off5", almost_empty === 1'b0);
    pulse_read(2);
    ck("ae_ptr3", rd_ptr_b === 4'd3);
    ck("ae_level4", level === 5'd4);
    neg(2);
    ck("hold_ptr", rd_ptr_b === 4'd3);
    ck("hold_en", rd_en === 1'b0);
    pulse_read(3);
    ck("ae_level3", level === 5'd3);
    ck("ae_off3", almost_empty === 1'b0);
    pulse_read(4);
    ck("ae_level2", level === 5'd2);
    ck("ae_on2", almost_empty === 1'b1);
    ck("ae_ptr5", rd_ptr_b === 4'd5);

    wr_ptr_g = gr(12);
    neg(3);
    ck("mid_level", level === 5'd7);
    rd_req_ = 1'b0;
    neg(2);
    ck("mid_en", rd_en === 1'b1);
    ck("mid_valid", rd_valid === 1'b1);
    #2;
    rst_     = 1'b0;
    wr_ptr_g = 4'b0000;
    #1;
    ck("arst_en", rd_en === 1'b0);
    ck("arst_valid", rd_valid === 1'b0);
    ck("arst_ptr", rd_ptr_b === 4'd0);
    ck("arst_empty", empty === 1'b1);
    neg(1);
    rst_ = 1'b1;
    for (int i = 0; i < 5; i++) begin
      neg(1);
      ck("post_rst_valid", rd_valid === 1'b0);
      ck("post_rst_en", rd_en === 1'b0);
    end
    wr_ptr_g = gr(1);
    neg(3);
    ck("new_en", rd_en === 1'b1);
    neg(1);
    ck("new_valid", rd_valid === 1'b1);
    ck("new_ptr", rd_ptr_b === 4'd1);
    rd_req_ = 1'b1;
    neg(1);

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rd_ctrl.md
# rd_ctrl

Read-side controller of the dual-clock gray-pointer FIFO. It pairs with the write-side controller.
- Brings the write pointer (gray) into the read clock domain and decodes it to binary.
- Owns the binary read address and issues the memory read enable.
- Publishes its own pointer in gray code back to the write domain.
- Generates empty, almost-empty, fill level and a read-data-valid qualifier for the registered FIFO memory.

## Interface
Parameters:
- ADDR_W, default 4: pointer width in bits; FIFO depth is 2^ADDR_W entries.
- SYNC_DLY, default 2: number of flop stages in the wr_ptr_g synchronizer.
- AE_THR, default 2: almost_empty asserts when level ≤ AE_THR.

Ports:
- rd_clk  in  1  read-domain clock; all flops are rising-edge.
- rst_  in  1  reset, asynchronous assert, active-low; applies to every flop, synchronizer stages included.
- wr_ptr_g  in  ADDR_W  gray-coded write pointer from the write domain; asynchronous to rd_clk.
- rd_req_  in  1  active-low read request; level-sensitive, one read per cycle while held low.
- rd_ptr_b  out  ADDR_W  binary read address to the FIFO memory; registered.
- rd_en  out  1  memory read enable; registered.
- rd_ptr_g  out  ADDR_W  gray code of rd_ptr_b, sent to the write domain; combinational from rd_ptr_b only.
- rd_valid  out  1  memory read data valid; equals rd_en delayed by one cycle.
- empty  out  1  no unread entry visible to the read domain.
- almost_empty  out  1  level ≤ AE_THR.
- level  out  ADDR_W+1  entries visible as written and not yet read, range 0..2^ADDR_W.

## Operation
- **Synchronizer:** wr_ptr_g passes through SYNC_DLY flops to give wr_g_s. A gray-to-binary decode of wr_g_s gives wr_b_s.
- **Pointer equality:** eq = (rd_ptr_b == wr_b_s). All pointer arithmetic is modulo 2^ADDR_W.
- **Underlap:** underlap = (rd_ptr_b + 1 == wr_b_s), i.e. one entry left. Registered as underlap_dly (reset 0).
- **Empty:** empty = eq && (underlap_dly || empty_dly). empty_dly is the registered empty, reset 1.
  - Equality reached by the reader catching up means empty.
  - Equality reached by the writer wrapping onto the reader means full: empty = 0, level = 2^ADDR_W.
- **Level:** level = empty ? 0 : (eq ? 2^ADDR_W : wr_b_s − rd_ptr_b).
- **Read enable:** next rd_en = !rd_req_ && (level > rd_en).
  - The issued-but-unretired read is subtracted, so the last entry is never read twice.
  - This gives reads at 1 per cycle with no overread.
- **Pointer advance:** rd_ptr_b increments by 1 on every cycle with rd_en = 1, wrapping 2^ADDR_W−1 → 0. Otherwise it holds.
- **Read data valid:** rd_valid <= rd_en. The memory registers its data at the rd_ptr_b presented during rd_en.
- **rd_req_ while empty:** ignored, with no pointer movement and no error state.
- **Reset values:** rd_ptr_b = 0, rd_ptr_g = 0, rd_en = 0, rd_valid = 0, empty = 1, almost_empty = 1, level = 0. All synchronizer stages = 0.
- **Reset mid-operation:** all state returns to reset values immediately. Any in-flight rd_valid is dropped. The write side must be reset in the same window.
- **Clock-ratio limit:** wr_clk ≤ 8× rd_clk, so wr_b_s never advances by 2^ADDR_W between samples.

## Timing
- wr_ptr_g change → wr_b_s updated after SYNC_DLY rd_clk edges.
- empty, level and almost_empty update in the same cycle as wr_b_s; they are combinational from registers only.
- rd_en is first asserted at the next edge, so SYNC_DLY+1 edges from the write to the first read issue.
- rd_req_ low with data present → rd_en high after 1 edge → rd_valid high after 2 edges.
- rd_ptr_b / rd_ptr_g advance at the edge that ends each rd_en cycle.
- Drain of N entries with rd_req_ held low: exactly N consecutive rd_en cycles.
  - rd_en drops in the cycle rd_ptr_b reaches wr_b_s − 1 with rd_en = 1.
  - empty asserts one cycle after the last rd_en cycle.

## Test plan
- **Reset:** rst_ low with wr_ptr_g = 4'b0110 → all outputs at reset values while low. After release, level = 4 and empty = 0 after 2 edges.
- **Single entry:** wr_ptr_g 0 → 1, rd_req_ held low → exactly one rd_en pulse at rd_ptr_b = 0, then rd_valid for one cycle, rd_ptr_b = 1, empty = 1, no second rd_en.
- **Full then drain:** writer fills 16 entries (wr_ptr_g wraps to 0) → empty = 0, level = 16. Hold rd_req_ low → 16 back-to-back rd_en, rd_ptr_b 0..15 → 0, then empty = 1.
- **Wrap-around:** rd_ptr_b starts at 14 with 4 entries written (wr_b_s = 2) → reads at 14, 15, 0, 1, with rd_ptr_g sequence 1001, 1000, 0000, 0001.
- **Almost-empty and request gaps:** with AE_THR = 2 and level 5, read 3 with rd_req_ pulsed → almost_empty asserts as level reaches 2. rd_req_ high holds rd_en = 0 and leaves pointers unchanged.
- **Mid-drain reset:** assert rst_ while rd_en = 1 and rd_valid = 1 → both outputs 0 asynchronously and rd_ptr_b = 0, with no rd_valid after release until new data arrives.
